// File: rtl/prng_lfsr_gen.sv
// prng_lfsr_gen: a control LFSR picks one bit from each pair of a 2*OUT_W data LFSR. A programmable divider paces the data LFSR.
// The word is registered one cycle after a tick. Under backpressure the held word is kept, the new word is dropped, and a sticky overrun is set. Option: PRNG_LOCKUP_RECOVER_EN.
module prng_lfsr_gen #(
    parameter int                 OUT_W     = 8,
    parameter logic [2*OUT_W-1:0] DATA_TAPS = 16'hD008,
    parameter logic [OUT_W-1:0]   CTRL_TAPS = 8'hB8,
    parameter int                 DIV_W     = 24
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 EN,
    input  logic [DIV_W-1:0]     div_period,
    input  logic                 seed_load,
    input  logic [2*OUT_W-1:0]   seed_data,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 lockup
);

    localparam int DW = 2 * OUT_W;

`ifdef PRNG_LOCKUP_RECOVER_EN
    localparam bit RECOVER = 1'b1;
`else
    localparam bit RECOVER = 1'b0;
`endif

    logic [DW-1:0]    data_q;
    logic [DW-1:0]    data_step;
    logic [OUT_W-1:0] ctrl_q;
    logic [OUT_W-1:0] ctrl_step;
    logic [OUT_W-1:0] word;
    logic [DIV_W-1:0] cnt_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_valid_q;
    logic             overrun_q;
    logic             lockup_q;
    logic             tick;
    logic             data_lock;
    logic             ctrl_lock;

    // A seed load swallows the tick of its cycle entirely.
    assign tick      = EN && (cnt_q >= div_period) && !seed_load;
    assign data_lock = RECOVER && (&data_q);
    assign ctrl_lock = RECOVER && (&ctrl_q);

    always_comb begin
        data_step = data_lock ? '0 : {data_q[DW-2:0], ~^(data_q & DATA_TAPS)};
        ctrl_step = ctrl_lock ? '0 : {ctrl_q[OUT_W-2:0], ~^(ctrl_q & CTRL_TAPS)};
        word      = '0;
        for (int j = 0; j < OUT_W; j++) begin
            word[j] = ctrl_q[j] ? data_q[2*j+1] : data_q[2*j];
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            data_q      <= '0;
            ctrl_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            lockup_q <= 1'b0;
            if (seed_load) begin
                data_q <= seed_data;
                ctrl_q <= seed_data[OUT_W-1:0] ^ seed_data[DW-1:OUT_W];
                cnt_q  <= '0;
            end else if (EN) begin
                ctrl_q   <= ctrl_step;
                cnt_q    <= tick ? '0 : cnt_q + DIV_W'(1);
                lockup_q <= (tick && data_lock) || ctrl_lock;
                if (tick) begin
                    data_q <= data_step;
                end
            end else begin
                cnt_q <= '0;
            end

            // A fresh drop outranks a clear in the same cycle.
            if (tick && out_valid_q && !out_ready) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end

            if (tick) begin
                if (!out_valid_q || out_ready) begin
                    out_data_q  <= word;
                    out_valid_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign lockup    = lockup_q;

endmodule

// File: tb/tb_prng_lfsr_gen.sv
// Scoreboard bench for prng_lfsr_gen: directed steps, a behavioural model and a queue of expected words.
module tb_prng_lfsr_gen;

    logic        CLK = 1'b0;
    logic        reset;
    logic        EN;
    logic [23:0] div_period;
    logic        seed_load;
    logic [15:0] seed_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        overrun_clr;
    logic        lockup;

    always #5 CLK = ~CLK;

    prng_lfsr_gen dut (
        .CLK         (CLK),
        .reset       (reset),
        .EN          (EN),
        .div_period  (div_period),
        .seed_load   (seed_load),
        .seed_data   (seed_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .lockup      (lockup)
    );

`ifdef PRNG_LOCKUP_RECOVER_EN
    localparam bit RECOVER = 1'b1;
`else
    localparam bit RECOVER = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  sb[$];
    logic [15:0] m_data;
    logic [7:0]  m_ctrl;
    logic [23:0] m_cnt;
    logic        m_valid;
    logic        m_ovr;
    logic        m_lock;

    function automatic logic [15:0] lfsr16(input logic [15:0] s);
        return {s[14:0], ~^(s & 16'hD008)};
    endfunction

    function automatic logic [7:0] lfsr8(input logic [7:0] s);
        return {s[6:0], ~^(s & 8'hB8)};
    endfunction

    function automatic logic [7:0] mkword(input logic [15:0] d, input logic [7:0] c);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[j] = c[j] ? d[2*j+1] : d[2*j];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: consume/compare on handshake, advance the model from the driven inputs, then check after the edge.
    task automatic step();
        logic       tk;
        logic [7:0] w;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'(out_valid), 32'd0);
            else                chk("sb_pop", 32'(out_data), 32'(sb.pop_front()));
        end
        if (reset) begin
            m_data = '0; m_ctrl = '0; m_cnt = '0;
            m_valid = 1'b0; m_ovr = 1'b0; m_lock = 1'b0;
            sb.delete();
        end else begin
            tk     = EN && (m_cnt >= div_period) && !seed_load;
            w      = mkword(m_data, m_ctrl);
            m_lock = 1'b0;
            if (tk && m_valid && !out_ready) m_ovr = 1'b1;
            else if (overrun_clr)            m_ovr = 1'b0;
            if (tk) begin
                if (!m_valid || out_ready) begin
                    m_valid = 1'b1;
                    sb.push_back(w);
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (seed_load) begin
                m_data = seed_data;
                m_ctrl = seed_data[7:0] ^ seed_data[15:8];
                m_cnt  = '0;
            end else if (EN) begin
                m_lock = (tk && RECOVER && (&m_data)) || (RECOVER && (&m_ctrl));
                if (tk) m_data = (RECOVER && (&m_data)) ? 16'h0 : lfsr16(m_data);
                m_ctrl = (RECOVER && (&m_ctrl)) ? 8'h0 : lfsr8(m_ctrl);
                m_cnt  = tk ? 24'd0 : m_cnt + 24'd1;
            end else begin
                m_cnt = '0;
            end
        end
        @(posedge CLK);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("lockup", 32'(lockup), 32'(m_lock));
        if (m_valid && sb.size() > 0) chk("out_data_head", 32'(out_data), 32'(sb[0]));
    endtask

    logic [7:0]  exp_w [4] = '{8'h00, 8'h00, 8'h01, 8'h01};
    logic [15:0] exp_d [4] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F};

    initial begin
        reset = 1'b1; EN = 1'b0; div_period = '0; seed_load = 1'b0; seed_data = '0;
        out_ready = 1'b0; overrun_clr = 1'b0;
        #2;
        step(); step();
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(dut.data_q), 32'h0);
        chk("rst_ctrl", 32'(dut.ctrl_q), 32'h0);
        chk("rst_cnt", 32'(dut.cnt_q), 32'h0);

        // Free-running at full rate: the first four words and data states are known constants.
        reset = 1'b0; EN = 1'b1; div_period = 24'd0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("a_word", 32'(out_data), 32'(exp_w[i]));
            chk("a_data", 32'(dut.data_q), 32'(exp_d[i]));
        end
        for (int i = 0; i < 20; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end

        // Divider of 4 with a stalled consumer: overrun, clear, same-cycle accept, seed on a tick.
        reset = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0; div_period = 24'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b_no_valid", 32'(out_valid), 32'h0);
        end
        step();
        chk("b_first_valid", 32'(out_valid), 32'h1);
        chk("b_first_word", 32'(out_data), 32'h00);
        for (int i = 0; i < 4; i++) step();
        chk("b_overrun_set", 32'(overrun), 32'h1);
        chk("b_word_kept", 32'(out_data), 32'h00);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("b_overrun_clr", 32'(overrun), 32'h0);
        step(); step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("c_accept_valid", 32'(out_valid), 32'h1);
        chk("c_accept_ovr", 32'(overrun), 32'h0);
        step(); step(); step();
        seed_load = 1'b1; seed_data = 16'h1234;
        step();
        seed_load = 1'b0;
        chk("d_seed_data", 32'(dut.data_q), 32'h1234);
        chk("d_seed_ctrl", 32'(dut.ctrl_q), 32'h26);
        chk("d_seed_cnt", 32'(dut.cnt_q), 32'h0);
        chk("d_seed_noword", 32'(overrun), 32'h0);

        // Drain, then hold EN low for 10 cycles mid-count.
        out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0;
        EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("e_no_tick", 32'(out_valid), 32'h0);
        end
        chk("e_cnt_zero", 32'(dut.cnt_q), 32'h0);
        chk("e_data_hold", 32'(dut.data_q), 32'h1234);
        chk("e_ctrl_hold", 32'(dut.ctrl_q), 32'(m_ctrl));
        EN = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("e_before_tick", 32'(out_valid), 32'h0);
        step();
        chk("e_tick_back", 32'(out_valid), 32'h1);

        // Mixed traffic against the model.
        for (int i = 0; i < 60; i++) begin
            EN          = ($urandom_range(0, 3) != 0);
            out_ready   = 1'($urandom_range(0, 1));
            overrun_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) div_period = 24'($urandom_range(0, 2));
            step();
        end
        EN = 1'b1; overrun_clr = 1'b0;

        // All-ones seed: recovered to zero with the option, stuck otherwise.
        reset = 1'b1;
        step();
        reset = 1'b0; div_period = 24'd0; out_ready = 1'b1;
        seed_load = 1'b1; seed_data = 16'hFFFF;
        step();
        seed_load = 1'b0;
`ifdef PRNG_LOCKUP_RECOVER_EN
        step();
        chk("f_recover_data", 32'(dut.data_q), 32'h0000);
        chk("f_lockup_pulse", 32'(lockup), 32'h1);
        chk("f_ones_word", 32'(out_data), 32'hFF);
        step();
        chk("f_lockup_end", 32'(lockup), 32'h0);
`else
        for (int i = 0; i < 4; i++) begin
            step();
            chk("f_stuck_data", 32'(dut.data_q), 32'hFFFF);
            chk("f_stuck_word", 32'(out_data), 32'hFF);
            chk("f_no_lockup", 32'(lockup), 32'h0);
        end
`endif

        if (m_valid && sb.size() > 0) chk("final_word", 32'(out_data), 32'(sb[0]));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
